// File: rtl/input_report_device.sv
// Debounced N-input sampler streaming framed reports {A,seq}, data bytes over a byte stream.
// Build option: define INPUT_REPORT_CHECKSUM_EN to append an XOR checksum byte to each report.
module input_report_device #(
  parameter int          NUM_INPUTS      = 8,
  parameter int          DEBOUNCE_CYCLES = 48000,
  parameter int          PERIOD_FRAMES   = 10,
  parameter logic [1:0]  RESET_MODE      = 2'd1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NUM_INPUTS-1:0] inputs_i,
  input  logic [10:0]           frame_i,
  input  logic                  usb_configured_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic [1:0]            mode_o
);
  localparam int NB = (NUM_INPUTS + 7) / 8;
  localparam int DW = NB * 8;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, CSUM} state_e;

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q, sample_q, deb_q, last_q, stable_d;
  logic [DW-1:0]         snap_q;
  logic [CW-1:0]         dcnt_q;
  logic [10:0]           frame_q;
  logic [7:0]            fcnt_q, in_data_q, next_byte_d;
  logic [1:0]            mode_q;
  logic [3:0]            seq_q;
  logic [2:0]            idx_q;
  logic                  in_valid_q, out_ready_q, pending_q;
  state_e                state_q;
  logic                  tick_d, cmd_fire_d, poll_d, term_d, frame_chg_d, periodic_d;
  logic                  change_d, start_d, in_fire_d, last_data_d;
`ifdef INPUT_REPORT_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign tick_d      = (dcnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign stable_d    = ~(sync2_q ^ sample_q);
  assign cmd_fire_d  = out_valid_i && out_ready_q;
  assign poll_d      = cmd_fire_d && (out_data_i == 8'h50);
  assign term_d      = cmd_fire_d && (out_data_i == 8'h54);
  assign frame_chg_d = (frame_i != frame_q);
  assign periodic_d  = (mode_q == 2'd2) && frame_chg_d && !term_d
                       && (fcnt_q == 8'(PERIOD_FRAMES - 1));
  assign change_d    = (mode_q == 2'd1) && (state_q == IDLE) && (deb_q != last_q);
  assign start_d     = (state_q == IDLE) && pending_q && usb_configured_i;
  // Byte stream: a byte moves only on a cycle with in_valid_o && in_ready_i; while
  // in_valid_o is high and in_ready_i low, in_data_o is held unchanged.
  assign in_fire_d   = in_valid_q && in_ready_i;
  assign last_data_d = (idx_q == 3'(NB - 1));
  assign next_byte_d = 8'(snap_q >> {idx_q + 3'd1, 3'b000});

  assign out_ready_o = out_ready_q;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;
  assign mode_o      = mode_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      dcnt_q   <= '0;
    end else begin
      sync1_q <= inputs_i;
      sync2_q <= sync1_q;
      dcnt_q  <= tick_d ? '0 : dcnt_q + CW'(1);
      // A bit follows the input only after two consecutive ticks agree.
      if (tick_d) begin
        sample_q <= sync2_q;
        deb_q    <= (deb_q & ~stable_d) | (sync2_q & stable_d);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_ready_q <= 1'b0;
      frame_q     <= '0;
      fcnt_q      <= '0;
      mode_q      <= RESET_MODE;
    end else begin
      out_ready_q <= usb_configured_i;
      frame_q     <= frame_i;
      if (cmd_fire_d) begin
        case (out_data_i)
          8'h53:   mode_q <= 2'd0;
          8'h43:   mode_q <= 2'd1;
          8'h54:   mode_q <= 2'd2;
          default: ;
        endcase
      end
      if (term_d)
        fcnt_q <= '0;
      else if ((mode_q == 2'd2) && frame_chg_d)
        fcnt_q <= periodic_d ? 8'd0 : fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      pending_q  <= 1'b0;
      seq_q      <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      last_q     <= '0;
`ifdef INPUT_REPORT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else if (!usb_configured_i) begin
      // Host gone: drop the partial report; seq and mode survive.
      state_q    <= IDLE;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      // The change trigger is already covered by the snapshot taken on start.
      pending_q <= start_d ? (poll_d | periodic_d)
                           : (pending_q | poll_d | periodic_d | change_d);
      case (state_q)
        IDLE: if (start_d) begin
          snap_q     <= DW'(deb_q);
          last_q     <= deb_q;
          in_valid_q <= 1'b1;
          in_data_q  <= {4'hA, seq_q};
`ifdef INPUT_REPORT_CHECKSUM_EN
          csum_q     <= {4'hA, seq_q};
`endif
          state_q    <= HEADER;
        end
        HEADER: if (in_fire_d) begin
          in_data_q <= snap_q[7:0];
`ifdef INPUT_REPORT_CHECKSUM_EN
          csum_q    <= csum_q ^ snap_q[7:0];
`endif
          idx_q     <= '0;
          state_q   <= DATA;
        end
        DATA: if (in_fire_d) begin
          if (last_data_d) begin
`ifdef INPUT_REPORT_CHECKSUM_EN
            in_data_q  <= csum_q;
            state_q    <= CSUM;
`else
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            seq_q      <= seq_q + 4'd1;
            state_q    <= IDLE;
`endif
          end else begin
            in_data_q <= next_byte_d;
`ifdef INPUT_REPORT_CHECKSUM_EN
            csum_q    <= csum_q ^ next_byte_d;
`endif
            idx_q     <= idx_q + 3'd1;
          end
        end
`ifdef INPUT_REPORT_CHECKSUM_EN
        CSUM: if (in_fire_d) begin
          in_valid_q <= 1'b0;
          in_data_q  <= '0;
          seq_q      <= seq_q + 4'd1;
          state_q    <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
